// File: rtl/video_sync_detect.sv
// video_sync_detect: recovers pixel position and line/frame geometry
// from an externally timed hsync/vsync/de stream and reports lock.
module video_sync_detect #(
  parameter int   H_BITS          = 12,
  parameter int   V_BITS          = 11,
  parameter logic H_SYNC_POLARITY = 1'b0,
  parameter logic V_SYNC_POLARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [H_BITS-1:0] h_count_o,
  output logic [V_BITS-1:0] v_count_o,
  output logic              end_of_line_o,
  output logic              frame_start_o,
  output logic [H_BITS-1:0] h_total_o,
  output logic [H_BITS-1:0] h_visible_o,
  output logic [V_BITS-1:0] v_total_o,
  output logic [V_BITS-1:0] v_visible_o,
  output logic              locked_o
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [H_BITS-1:0] H_MAX = '1;
  localparam logic [V_BITS-1:0] V_MAX = '1;
  localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);
  localparam logic [V_BITS-1:0] V_ONE = V_BITS'(1);

  logic hsync_r, vsync_r, de_r;
  logic hs_p, vs_p, de_p;
  logic hs, vs;
  logic hs_start, vs_start, de_rise, de_fall;

  assign hs       = (hsync_r == H_SYNC_POLARITY);
  assign vs       = (vsync_r == V_SYNC_POLARITY);
  assign hs_start = hs & ~hs_p;
  assign vs_start = vs & ~vs_p;
  assign de_rise  = de_r & ~de_p;
  assign de_fall  = ~de_r & de_p;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hsync_r <= ~H_SYNC_POLARITY;
      vsync_r <= ~V_SYNC_POLARITY;
      de_r    <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
      de_p    <= 1'b0;
    end else begin
      hsync_r <= hsync_i;
      vsync_r <= vsync_i;
      de_r    <= de_i;
      hs_p    <= hs;
      vs_p    <= vs;
      de_p    <= de_r;
    end
  end

  logic [H_BITS-1:0] lc, rc, lc_inc, rc_inc;
  logic [H_BITS-1:0] meas_ht, meas_hv;
  logic [V_BITS-1:0] vl, vd, vl_inc, vd_inc;
  logic              lc_sat;

  assign lc_sat = (lc == H_MAX);
  assign lc_inc = lc_sat ? lc : lc + H_ONE;
  assign rc_inc = (rc == H_MAX) ? rc : rc + H_ONE;
  assign vl_inc = (vl == V_MAX) ? vl : vl + V_ONE;
  assign vd_inc = (vd == V_MAX) ? vd : vd + V_ONE;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      lc      <= '0;
      rc      <= '0;
      vl      <= '0;
      vd      <= '0;
      meas_ht <= '0;
      meas_hv <= '0;
    end else begin
      if (hs_start) begin
        meas_ht <= lc_inc;
        lc      <= '0;
      end else begin
        lc <= lc_inc;
      end
      if (de_fall) meas_hv <= rc;
      if (de_rise) rc <= H_ONE;
      else if (de_r) rc <= rc_inc;
      // a sync edge coincident with vsync belongs to the new frame
      if (vs_start) begin
        vl <= hs_start ? V_ONE : '0;
        vd <= de_rise ? V_ONE : '0;
      end else begin
        if (hs_start) vl <= vl_inc;
        if (de_rise) vd <= vd_inc;
      end
    end
  end

  logic [H_BITS-1:0] st_ht, st_hv;
  logic [V_BITS-1:0] st_vt, st_vv;
  logic              cand_ok, eq_st, eq_pub;

  assign cand_ok = (meas_ht != '0) && (meas_ht != H_MAX)
                && (meas_hv != '0) && (meas_hv != H_MAX)
                && (vl != '0) && (vl != V_MAX)
                && (vd != '0) && (vd != V_MAX);
  assign eq_st  = (meas_ht == st_ht) && (meas_hv == st_hv)
               && (vl == st_vt) && (vd == st_vv);
  assign eq_pub = (meas_ht == h_total_o) && (meas_hv == h_visible_o)
               && (vl == v_total_o) && (vd == v_visible_o);

  state_t state, state_nx;
  logic   store, store_hs, publish, clear;

  always_ff @(posedge clk) begin
    if (reset_i) state <= SEARCH;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    store    = 1'b0;
    store_hs = 1'b0;
    publish  = 1'b0;
    clear    = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_start) begin
          state_nx = MEASURE;
          clear    = 1'b1;
        end
      end
      MEASURE: begin
        if (vs_start) begin
          if (eq_st && cand_ok) begin
            state_nx = LOCKED;
            publish  = 1'b1;
          end else begin
            store = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (vs_start && !eq_pub) begin
          state_nx = MEASURE;
          store    = 1'b1;
        end else if (hs_start && (lc_inc != h_total_o)) begin
          state_nx = MEASURE;
          store_hs = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
    // hsync lost overrides everything
    if (lc_sat) state_nx = SEARCH;
  end

  assign locked_o = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset_i || clear) begin
      st_ht <= '0;
      st_hv <= '0;
      st_vt <= '0;
      st_vv <= '0;
    end else if (store || store_hs) begin
      st_ht <= store_hs ? lc_inc : meas_ht;
      st_hv <= meas_hv;
      st_vt <= vl;
      st_vv <= vd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      h_total_o   <= '0;
      h_visible_o <= '0;
      v_total_o   <= '0;
      v_visible_o <= '0;
    end else if (publish) begin
      h_total_o   <= meas_ht;
      h_visible_o <= meas_hv;
      v_total_o   <= vl;
      v_visible_o <= vd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hsync_o       <= ~H_SYNC_POLARITY;
      vsync_o       <= ~V_SYNC_POLARITY;
      de_o          <= 1'b0;
      end_of_line_o <= 1'b0;
      frame_start_o <= 1'b0;
      h_count_o     <= '0;
      v_count_o     <= '0;
    end else begin
      hsync_o       <= hsync_r;
      vsync_o       <= vsync_r;
      de_o          <= de_r;
      end_of_line_o <= de_fall;
      frame_start_o <= vs_start;
      if (de_r) begin
        if (de_rise)               h_count_o <= '0;
        else if (h_count_o != H_MAX) h_count_o <= h_count_o + H_ONE;
      end
      if (vs_start)                          v_count_o <= '0;
      else if (de_fall && v_count_o != V_MAX) v_count_o <= v_count_o + V_ONE;
    end
  end

endmodule

// File: tb/tb_video_sync_detect.sv
// tb_video_sync_detect: random small video timings driven through the
// detector and compared against a pixel/frame level reference.
module tb_video_sync_detect;

  localparam int HB = 12;
  localparam int VB = 11;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          hsync_i = 1'b1;
  logic          vsync_i = 1'b1;
  logic          de_i = 1'b0;
  logic          hsync_o, vsync_o, de_o;
  logic [HB-1:0] h_count_o, h_total_o, h_visible_o;
  logic [VB-1:0] v_count_o, v_total_o, v_visible_o;
  logic          end_of_line_o, frame_start_o, locked_o;

  always #5 clk = ~clk;

  video_sync_detect dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .de_i         (de_i),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .de_o         (de_o),
    .h_count_o    (h_count_o),
    .v_count_o    (v_count_o),
    .end_of_line_o(end_of_line_o),
    .frame_start_o(frame_start_o),
    .h_total_o    (h_total_o),
    .h_visible_o  (h_visible_o),
    .v_total_o    (v_total_o),
    .v_visible_o  (v_visible_o),
    .locked_o     (locked_o)
  );

  typedef struct {
    bit de, hs, vs, loss, hsen, rst;
    int x, y;
  } pix_t;

  pix_t p1, p2, p3;
  int   ht, hv, hs_a, hsw, vt, vv, vs_a, vsw, vs_x;
  int   gx, gy, long_y, wraps;
  bit   tag_next, hsen, rst_drv;
  int   total, bad;
  int   q, need, e_ht, e_hv, e_vt, e_vv;
  bit   exp_lk, xmode, pos_ok;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_geom(input bit coinc);
    ht   = $urandom_range(56, 40);
    hv   = $urandom_range(ht - 16, 16);
    hs_a = hv + $urandom_range(4, 2);
    hsw  = $urandom_range(5, 2);
    vv   = $urandom_range(12, 6);
    vs_a = vv + $urandom_range(2, 1);
    vsw  = 2;
    vt   = vs_a + vsw + $urandom_range(4, 1);
    if (coinc) vs_x = hs_a;
    else       vs_x = (hs_a + 1 + $urandom_range(ht - 2, 0)) % ht;
  endtask

  task automatic step();
    pix_t e2, e3, np;
    bit   hse, fse;
    int   len;
    @(negedge clk);
    e2 = p2;
    e3 = p3;
    if (p2.rst || p3.rst) begin
      e3.de = 0; e3.hs = 0; e3.vs = 0;
    end
    if (p2.rst || p1.rst) begin
      e2.de = 0; e2.hs = 0; e2.vs = 0;
    end
    if (p1.rst) begin
      e3.de = 0; e3.hs = 0; e3.vs = 0;
      exp_lk = 0; need = 3; pos_ok = 0; q = 0; xmode = 0;
      e_ht = 0; e_hv = 0; e_vt = 0; e_vv = 0;
    end
    hse = e2.hs & ~e3.hs;
    fse = e2.vs & ~e3.vs;
    if (!p1.rst) begin
      if (hse) q = 0;
      else if (q < 8000) q++;
      if (!p2.hsen && q < 4096) xmode = 1;
      if (q >= 4096) begin
        exp_lk = 0; need = 3; xmode = 0;
      end else if (!xmode) begin
        if (p2.loss) begin
          exp_lk = 0; need = 2;
        end
        if (fse && need > 0) begin
          need--;
          if (need == 0) begin
            exp_lk = 1;
            e_ht = ht; e_hv = hv; e_vt = vt; e_vv = vv;
          end
        end
      end
      if (fse) pos_ok = 1;
    end
    chk("de", de_o, e2.de);
    chk("hsync", hsync_o, !e2.hs);
    chk("vsync", vsync_o, !e2.vs);
    chk("eol", end_of_line_o, e3.de & ~e2.de);
    chk("frame_start", frame_start_o, fse);
    if (!xmode) chk("locked", locked_o, exp_lk);
    chk("h_total", h_total_o, e_ht);
    chk("h_visible", h_visible_o, e_hv);
    chk("v_total", v_total_o, e_vt);
    chk("v_visible", v_visible_o, e_vv);
    if (p1.rst) begin
      chk("h_count_rst", h_count_o, 0);
      chk("v_count_rst", v_count_o, 0);
    end else if (e2.de && pos_ok) begin
      chk("h_count", h_count_o, e2.x);
      chk("v_count", v_count_o, e2.y);
    end
    np.x    = gx;
    np.y    = gy;
    np.hsen = hsen;
    np.rst  = rst_drv;
    np.de   = (gx < hv) && (gy < vv);
    np.hs   = hsen && (gx >= hs_a) && (gx < hs_a + hsw);
    np.vs   = (gy > vs_a || (gy == vs_a && gx >= vs_x))
           && (gy < vs_a + vsw || (gy == vs_a + vsw && gx < vs_x));
    np.loss = tag_next && np.hs && (gx == hs_a);
    if (np.loss) tag_next = 0;
    hsync_i = !np.hs;
    vsync_i = !np.vs;
    de_i    = np.de;
    reset_i = rst_drv;
    p3 = p2;
    p2 = p1;
    p1 = np;
    len = (gy == long_y) ? ht + 1 : ht;
    gx++;
    if (gx == len) begin
      gx = 0;
      if (gy == long_y) begin
        long_y   = -1;
        tag_next = 1;
      end
      gy++;
      if (gy == vt) begin
        gy = 0;
        wraps++;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int w0;
    w0 = wraps;
    while (wraps < w0 + n) step();
  endtask

  initial begin
    int ry;
    total = 0; bad = 0;
    p1 = '{default: 0}; p1.rst = 1; p1.hsen = 1;
    p2 = p1; p3 = p1;
    gx = 0; gy = 0; wraps = 0; long_y = -1;
    tag_next = 0; hsen = 1; rst_drv = 1;
    exp_lk = 0; need = 3; q = 0; xmode = 0; pos_ok = 0;
    e_ht = 0; e_hv = 0; e_vt = 0; e_vv = 0;

    set_geom(0);
    repeat (4) step();
    chk("reset_locked", locked_o, 0);
    chk("reset_h_total", h_total_o, 0);
    rst_drv = 0;
    run_frames(4);
    chk("lock_a", locked_o, 1);
    chk("geom_ht", h_total_o, ht);
    chk("geom_vt", v_total_o, vt);

    long_y = $urandom_range(vv - 2, 1);
    run_frames(3);
    chk("relock_long", locked_o, 1);

    hsen = 0;
    repeat (4600) step();
    chk("hs_lost", locked_o, 0);
    chk("hs_lost_hold", h_total_o, ht);
    hsen = 1;
    run_frames(4);
    chk("relock_hs", locked_o, 1);

    ry = $urandom_range(vv - 2, 1);
    while (gy != ry || gx != 0) step();
    repeat ($urandom_range(ht - 1, 1)) step();
    rst_drv = 1;
    repeat (3) step();
    chk("mid_reset_locked", locked_o, 0);
    chk("mid_reset_v_total", v_total_o, 0);
    rst_drv = 0;
    run_frames(4);
    chk("relock_reset", locked_o, 1);

    set_geom(1);
    rst_drv = 1;
    repeat (3) step();
    rst_drv = 0;
    run_frames(4);
    chk("lock_coinc", locked_o, 1);
    chk("coinc_v_total", v_total_o, vt);
    chk("coinc_h_total", h_total_o, ht);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
